dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
Shares the single data-memory port between the pipelined core's load/store stage and a host/debug port. The host port preloads matrix operands and reads back results without halting the core. Sits in top between the core memory stage and dmem.
- Core has priority by default.
- A host starvation counter forces bounded host bursts.
- Read data is returned registered, one cycle after grant.

Parameters:
AW, 32, address width
DW, 32, data width
STARVE_LIMIT, 8, consecutive denied host cycles before host is forced priority (>=1)
HOST_BURST_MAX, 4, maximum consecutive host grants while holding priority (>=1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous active-low reset (0 = reset asserted)
core_req  in  1  core access request
core_we  in  1  core write enable (1 = write, 0 = read)
core_addr  in  AW  core byte address, word aligned
core_wdata  in  DW  core write data
core_gnt  out  1  core access performed this cycle
core_stall  out  1  core_req & ~core_gnt
core_rvalid  out  1  core read data valid (cycle after granted read)
core_rdata  out  DW  registered core read data
host_req / host_we / host_addr / host_wdata  in  1/1/AW/DW  host request fields
host_gnt  out  1  host access performed this cycle
host_rvalid  out  1  host read data valid
host_rdata  out  DW  registered host read data
mem_we  out  1  memory write strobe
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data (combinational read)

Behaviour:
- Grants are combinational from request inputs and current state; at most one grant per cycle. mem_* mux the granted port's fields. With no grant: mem_we=0, mem_addr=0, mem_wdata=0.
- Memory writes take effect at the clock edge ending the grant cycle.
- Granted read: the selected rdata register captures mem_rdata and the matching rvalid pulses for exactly one cycle. No rvalid is produced for writes.
- Only one requester active: that requester is granted, regardless of state.
- wait_cnt:
  - increments when host_req & ~host_gnt, saturating at STARVE_LIMIT;
  - clears on host grant or when host_req=0.
- FSM S_CORE (reset state), on conflict:
  - core wins if wait_cnt < STARVE_LIMIT;
  - otherwise host wins, next state S_HOST, burst_cnt=1.
- FSM S_HOST, on conflict: host wins and burst_cnt increments per host grant.
- S_HOST returns to S_CORE, clearing burst_cnt, when either:
  - a host grant brings burst_cnt to HOST_BURST_MAX, or
  - host_req=0.
- In S_HOST, a cycle with core_req=0 and host_req=1 still counts toward the burst.
- Reset is asynchronous. Every output register goes to 0 immediately: rvalids=0, rdata=0, state S_CORE, wait_cnt=0, burst_cnt=0. A read granted in the cycle reset asserts never produces rvalid.
- Counter widths are $clog2(limit)+1. No wrap: wait_cnt saturates; burst_cnt is bounded by the FSM.

Optional Feature:
DMEM_ARB_STATS_EN: adds outputs stat_core_gnts, stat_host_gnts and stat_conflicts (32 bits each).
- Each counts its event per cycle and saturates at all-ones.
- All clear on reset.
- Without the macro these ports and registers do not exist and arbitration is unchanged.

Decomposition:
- Shared package dmem_arb_pkg holds:
  - the state enum {S_CORE, S_HOST};
  - the port-select constants PORT_CORE=0 and PORT_HOST=1.
- One natural sub-module, dmem_arb_fsm: state, wait_cnt, burst_cnt and grant decisions.
- The top level keeps the data muxing and response registers.

Test Plan:
- RAM[8]=0x40800000; core-only read of 0x20 -> core_gnt=1, core_stall=0 same cycle; next cycle core_rvalid=1, core_rdata=0x40800000.
- Host write 0x41100000 to 0x2C, core idle -> mem_we=1, mem_addr=0x2C; a following core read returns 0x41100000.
- Both request every cycle, defaults:
  - core granted cycles 0-7;
  - host granted cycles 8-11, with core_stall=1;
  - core again cycles 12-19;
  - pattern repeats.
- Forced host burst; host_req drops after 2 grants -> S_CORE next cycle, wait_cnt=0, the next conflict goes to core.
- reset driven to 0 mid-burst with a host read granted that cycle -> all outputs 0 without a clock edge; after release there is no host_rvalid, and the first conflict grants core.
- With DMEM_ARB_STATS_EN, scenario 3 run for 12 cycles -> stat_core_gnts=8, stat_host_gnts=4, stat_conflicts=12.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// Optional statistics counters are enabled with DMEM_ARB_STATS_EN.
package dmem_arb_pkg;

  typedef logic [0:0] arb_state_t;

  localparam arb_state_t S_CORE = 1'b0;
  localparam arb_state_t S_HOST = 1'b1;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_HOST = 1'b1;

  // Saturating 32-bit event counter step; sticks at all-ones.
  function automatic logic [31:0] sat_inc32(input logic [31:0] value, input logic event_hit);
    logic [31:0] result;
    if (event_hit && (value != 32'hFFFF_FFFF)) begin
      result = value + 32'd1;
    end else begin
      result = value;
    end
    return result;
  endfunction

endpackage

// File: rtl/dmem_arb_fsm.sv
// Grant decision for core vs. host: core priority, starvation counter and
// bounded host bursts. Grants are combinational and suppressed during reset.
module dmem_arb_fsm
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT   = 8,
  parameter int HOST_BURST_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic core_req,
  input  logic host_req,
  output logic core_gnt,
  output logic host_gnt
);

  localparam int WW = $clog2(STARVE_LIMIT) + 1;
  localparam int BW = $clog2(HOST_BURST_MAX) + 1;
  localparam logic [WW-1:0] STARVE_LIM_C = WW'(STARVE_LIMIT);
  localparam logic [BW-1:0] BURST_MAX_C  = BW'(HOST_BURST_MAX);

  arb_state_t    state_r, state_n;
  logic [WW-1:0] wait_cnt_r, wait_cnt_n;
  logic [BW-1:0] burst_cnt_r, burst_cnt_n;
  logic          conflict_s, host_win_s;

  // Arbitration: the host only wins a conflict when starved or mid-burst.
  always_comb begin
    conflict_s = core_req & host_req;
    host_win_s = 1'b0;
    if (conflict_s) begin
      if (state_r == S_HOST) begin
        host_win_s = 1'b1;
      end else if (wait_cnt_r >= STARVE_LIM_C) begin
        host_win_s = 1'b1;
      end else begin
        host_win_s = 1'b0;
      end
    end else begin
      host_win_s = host_req;
    end
    host_gnt = host_win_s & reset;
    core_gnt = core_req & ~host_win_s & reset;
  end

  // Next-state, burst and starvation counter update.
  always_comb begin
    state_n     = state_r;
    burst_cnt_n = burst_cnt_r;
    wait_cnt_n  = wait_cnt_r;
    if (!host_req || host_gnt) begin
      wait_cnt_n = {WW{1'b0}};
    end else if (wait_cnt_r < STARVE_LIM_C) begin
      wait_cnt_n = wait_cnt_r + WW'(1);
    end else begin
      wait_cnt_n = wait_cnt_r;
    end
    case (state_r)
      S_CORE: begin
        // A burst limit of one means the forced grant is the whole burst.
        if (conflict_s && host_gnt && (BURST_MAX_C > BW'(1))) begin
          state_n     = S_HOST;
          burst_cnt_n = BW'(1);
        end else begin
          state_n     = S_CORE;
          burst_cnt_n = {BW{1'b0}};
        end
      end
      S_HOST: begin
        if (!host_req) begin
          state_n     = S_CORE;
          burst_cnt_n = {BW{1'b0}};
        end else if (host_gnt && ((burst_cnt_r + BW'(1)) >= BURST_MAX_C)) begin
          state_n     = S_CORE;
          burst_cnt_n = {BW{1'b0}};
        end else if (host_gnt) begin
          state_n     = S_HOST;
          burst_cnt_n = burst_cnt_r + BW'(1);
        end else begin
          state_n     = S_HOST;
          burst_cnt_n = burst_cnt_r;
        end
      end
      default: begin
        state_n     = S_CORE;
        burst_cnt_n = {BW{1'b0}};
      end
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= S_CORE;
      wait_cnt_r  <= {WW{1'b0}};
      burst_cnt_r <= {BW{1'b0}};
    end else begin
      state_r     <= state_n;
      wait_cnt_r  <= wait_cnt_n;
      burst_cnt_r <= burst_cnt_n;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the data-memory port between the core memory stage and the host port.
// Define DMEM_ARB_STATS_EN to add saturating grant/conflict statistics outputs.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int STARVE_LIMIT   = 8,
  parameter int HOST_BURST_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic          core_gnt,
  output logic          core_stall,
  output logic          core_rvalid,
  output logic [DW-1:0] core_rdata,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]   stat_core_gnts,
  output logic [31:0]   stat_host_gnts,
  output logic [31:0]   stat_conflicts
`endif
);

  logic core_gnt_s, host_gnt_s, sel_s, grant_any_s;

  dmem_arb_fsm #(
    .STARVE_LIMIT  (STARVE_LIMIT),
    .HOST_BURST_MAX(HOST_BURST_MAX)
  ) u_fsm (
    .clk     (clk),
    .reset   (reset),
    .core_req(core_req),
    .host_req(host_req),
    .core_gnt(core_gnt_s),
    .host_gnt(host_gnt_s)
  );

  assign core_gnt   = core_gnt_s;
  assign host_gnt   = host_gnt_s;
  assign core_stall = core_req & ~core_gnt_s & reset;

  // Memory-side mux of the granted port; idle bus is driven to zero.
  always_comb begin
    grant_any_s = core_gnt_s | host_gnt_s;
    sel_s       = host_gnt_s ? PORT_HOST : PORT_CORE;
    mem_we      = 1'b0;
    mem_addr    = {AW{1'b0}};
    mem_wdata   = {DW{1'b0}};
    if (grant_any_s) begin
      case (sel_s)
        PORT_CORE: begin
          mem_we    = core_we;
          mem_addr  = core_addr;
          mem_wdata = core_wdata;
        end
        PORT_HOST: begin
          mem_we    = host_we;
          mem_addr  = host_addr;
          mem_wdata = host_wdata;
        end
        default: begin
          mem_we    = 1'b0;
          mem_addr  = {AW{1'b0}};
          mem_wdata = {DW{1'b0}};
        end
      endcase
    end else begin
      mem_we    = 1'b0;
      mem_addr  = {AW{1'b0}};
      mem_wdata = {DW{1'b0}};
    end
  end

  // Read response registers: data captured on a granted read, valid pulses once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      core_rvalid <= 1'b0;
      core_rdata  <= {DW{1'b0}};
      host_rvalid <= 1'b0;
      host_rdata  <= {DW{1'b0}};
    end else begin
      core_rvalid <= core_gnt_s & ~core_we;
      host_rvalid <= host_gnt_s & ~host_we;
      if (core_gnt_s && !core_we) begin
        core_rdata <= mem_rdata;
      end
      if (host_gnt_s && !host_we) begin
        host_rdata <= mem_rdata;
      end
    end
  end

`ifdef DMEM_ARB_STATS_EN
  // Saturating usage statistics.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_core_gnts <= 32'd0;
      stat_host_gnts <= 32'd0;
      stat_conflicts <= 32'd0;
    end else begin
      stat_core_gnts <= sat_inc32(stat_core_gnts, core_gnt_s);
      stat_host_gnts <= sat_inc32(stat_host_gnts, host_gnt_s);
      stat_conflicts <= sat_inc32(stat_conflicts, core_req & host_req);
    end
  end
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed self-checking bench for dmem_port_arbiter with a small word RAM model.
// Statistics checks are compiled in when DMEM_ARB_STATS_EN is defined.
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_req, core_we, core_gnt, core_stall, core_rvalid;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        host_req, host_we, host_gnt, host_rvalid;
  logic [31:0] host_addr, host_wdata, host_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic [31:0] stat_core_gnts, stat_host_gnts, stat_conflicts;
`endif

  logic [31:0] ram [0:63];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_gnt   (core_gnt),
    .core_stall (core_stall),
    .core_rvalid(core_rvalid),
    .core_rdata (core_rdata),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_gnt   (host_gnt),
    .host_rvalid(host_rvalid),
    .host_rdata (host_rdata),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    ,
    .stat_core_gnts(stat_core_gnts),
    .stat_host_gnts(stat_host_gnts),
    .stat_conflicts(stat_conflicts)
`endif
  );

  assign mem_rdata = ram[mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr[7:2]] <= mem_wdata;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h20;
    #2;
    checks++; if (core_gnt !== 1'b0) begin errors++; $display("FAIL reset_core_gnt: got %b expected 0", core_gnt); end
    checks++; if (core_stall !== 1'b0) begin errors++; $display("FAIL reset_core_stall: got %b expected 0", core_stall); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    checks++; if (core_rvalid !== 1'b0 || host_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b%b expected 00", core_rvalid, host_rvalid); end
    checks++; if (core_rdata !== 32'h0 || host_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h/%h expected 0", core_rdata, host_rdata); end
    core_req = 1'b0;
    next_cycle();
    reset = 1'b1;
  endtask

  task automatic test_core_read();
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h20;
    @(negedge clk);
    checks++; if (core_gnt !== 1'b1) begin errors++; $display("FAIL cread_gnt: got %b expected 1", core_gnt); end
    checks++; if (core_stall !== 1'b0) begin errors++; $display("FAIL cread_stall: got %b expected 0", core_stall); end
    checks++; if (mem_addr !== 32'h20 || mem_we !== 1'b0) begin errors++; $display("FAIL cread_mem: got %h/%b expected 00000020/0", mem_addr, mem_we); end
    next_cycle();
    core_req = 1'b0;
    checks++; if (core_rvalid !== 1'b1) begin errors++; $display("FAIL cread_rvalid: got %b expected 1", core_rvalid); end
    checks++; if (core_rdata !== 32'h4080_0000) begin errors++; $display("FAIL cread_rdata: got %h expected 40800000", core_rdata); end
    next_cycle();
    checks++; if (core_rvalid !== 1'b0) begin errors++; $display("FAIL cread_pulse: got %b expected 0", core_rvalid); end
    checks++; if (core_rdata !== 32'h4080_0000) begin errors++; $display("FAIL cread_hold: got %h expected 40800000", core_rdata); end
  endtask

  task automatic test_host_write();
    host_req = 1'b1; host_we = 1'b1; host_addr = 32'h2C; host_wdata = 32'h4110_0000;
    @(negedge clk);
    checks++; if (host_gnt !== 1'b1) begin errors++; $display("FAIL hwrite_gnt: got %b expected 1", host_gnt); end
    checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h2C) begin errors++; $display("FAIL hwrite_mem: got %b/%h expected 1/0000002c", mem_we, mem_addr); end
    checks++; if (mem_wdata !== 32'h4110_0000) begin errors++; $display("FAIL hwrite_wdata: got %h expected 41100000", mem_wdata); end
    next_cycle();
    host_req = 1'b0; host_we = 1'b0;
    checks++; if (host_rvalid !== 1'b0) begin errors++; $display("FAIL hwrite_no_rvalid: got %b expected 0", host_rvalid); end
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h2C;
    next_cycle();
    core_req = 1'b0;
    checks++; if (core_rvalid !== 1'b1 || core_rdata !== 32'h4110_0000) begin errors++; $display("FAIL hwrite_readback: got %b/%h expected 1/41100000", core_rvalid, core_rdata); end
    next_cycle();
  endtask

  task automatic test_conflict();
    logic exp_host;
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h20;
    host_req = 1'b1; host_we = 1'b0; host_addr = 32'h2C;
    for (int i = 0; i < 24; i++) begin
      exp_host = ((i % 12) >= 8);
      @(negedge clk);
      checks++; if (host_gnt !== exp_host || core_gnt !== !exp_host) begin errors++; $display("FAIL conflict_gnt cycle %0d: got core=%b host=%b expected host=%b", i, core_gnt, host_gnt, exp_host); end
      checks++; if (core_stall !== exp_host) begin errors++; $display("FAIL conflict_stall cycle %0d: got %b expected %b", i, core_stall, exp_host); end
      checks++; if (mem_addr !== (exp_host ? 32'h2C : 32'h20)) begin errors++; $display("FAIL conflict_addr cycle %0d: got %h", i, mem_addr); end
      next_cycle();
      checks++; if (host_rvalid !== exp_host || core_rvalid !== !exp_host) begin errors++; $display("FAIL conflict_rvalid cycle %0d: got core=%b host=%b expected host=%b", i, core_rvalid, host_rvalid, exp_host); end
      if (exp_host) begin
        checks++; if (host_rdata !== 32'h4110_0000) begin errors++; $display("FAIL conflict_hdata cycle %0d: got %h expected 41100000", i, host_rdata); end
      end else begin
        checks++; if (core_rdata !== 32'h4080_0000) begin errors++; $display("FAIL conflict_cdata cycle %0d: got %h expected 40800000", i, core_rdata); end
      end
    end
    core_req = 1'b0; host_req = 1'b0;
    next_cycle();
  endtask

  task automatic test_burst_drop();
    core_req = 1'b1; host_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (host_gnt !== (i >= 8)) begin errors++; $display("FAIL burst_gnt cycle %0d: got %b expected %b", i, host_gnt, (i >= 8)); end
      next_cycle();
    end
    host_req = 1'b0;
    @(negedge clk);
    checks++; if (core_gnt !== 1'b1 || core_stall !== 1'b0) begin errors++; $display("FAIL burst_drop_core: got gnt=%b stall=%b expected 1/0", core_gnt, core_stall); end
    next_cycle();
    host_req = 1'b1;
    @(negedge clk);
    checks++; if (core_gnt !== 1'b1 || host_gnt !== 1'b0) begin errors++; $display("FAIL burst_after_conflict: got core=%b host=%b expected 1/0", core_gnt, host_gnt); end
    next_cycle();
    core_req = 1'b0; host_req = 1'b0;
    next_cycle();
  endtask

  task automatic test_reset_mid_burst();
    core_req = 1'b1; core_addr = 32'h20; host_req = 1'b1; host_we = 1'b0; host_addr = 32'h2C;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 9) begin
        checks++; if (host_gnt !== 1'b1) begin errors++; $display("FAIL rst_burst_pre: got %b expected 1", host_gnt); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (host_gnt !== 1'b0 || core_gnt !== 1'b0) begin errors++; $display("FAIL rst_burst_gnt: got core=%b host=%b expected 0/0", core_gnt, host_gnt); end
        checks++; if (host_rvalid !== 1'b0 || host_rdata !== 32'h0) begin errors++; $display("FAIL rst_burst_host_resp: got %b/%h expected 0/0", host_rvalid, host_rdata); end
        checks++; if (core_rdata !== 32'h0 || core_stall !== 1'b0) begin errors++; $display("FAIL rst_burst_core: got %h/%b expected 0/0", core_rdata, core_stall); end
        checks++; if (mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_burst_mem: got %b/%h/%h expected zero", mem_we, mem_addr, mem_wdata); end
        core_req = 1'b0; host_req = 1'b0;
      end
      next_cycle();
    end
    reset = 1'b1;
    next_cycle();
    checks++; if (host_rvalid !== 1'b0 || core_rvalid !== 1'b0) begin errors++; $display("FAIL rst_release_rvalid: got core=%b host=%b expected 0/0", core_rvalid, host_rvalid); end
    core_req = 1'b1; host_req = 1'b1;
    @(negedge clk);
    checks++; if (core_gnt !== 1'b1 || host_gnt !== 1'b0) begin errors++; $display("FAIL rst_first_conflict: got core=%b host=%b expected 1/0", core_gnt, host_gnt); end
    next_cycle();
    core_req = 1'b0; host_req = 1'b0;
    next_cycle();
  endtask

`ifdef DMEM_ARB_STATS_EN
  task automatic test_stats();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    checks++; if (stat_core_gnts !== 32'd0 || stat_host_gnts !== 32'd0 || stat_conflicts !== 32'd0) begin errors++; $display("FAIL stats_reset: got %0d/%0d/%0d expected 0/0/0", stat_core_gnts, stat_host_gnts, stat_conflicts); end
    core_req = 1'b1; host_req = 1'b1;
    for (int i = 0; i < 12; i++) next_cycle();
    core_req = 1'b0; host_req = 1'b0;
    next_cycle();
    checks++; if (stat_core_gnts !== 32'd8) begin errors++; $display("FAIL stats_core: got %0d expected 8", stat_core_gnts); end
    checks++; if (stat_host_gnts !== 32'd4) begin errors++; $display("FAIL stats_host: got %0d expected 4", stat_host_gnts); end
    checks++; if (stat_conflicts !== 32'd12) begin errors++; $display("FAIL stats_conflicts: got %0d expected 12", stat_conflicts); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 64; i++) ram[i] = 32'h0;
    ram[8] = 32'h4080_0000;
    reset = 1'b0;
    core_req = 1'b0; core_we = 1'b0; core_addr = 32'h0; core_wdata = 32'h0;
    host_req = 1'b0; host_we = 1'b0; host_addr = 32'h0; host_wdata = 32'h0;
    test_reset();
    test_core_read();
    test_host_write();
    test_conflict();
    test_burst_drop();
    test_reset_mid_burst();
`ifdef DMEM_ARB_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
